// File: rtl/tdm_demux_if.sv
// Bus bundle for the 4-slot TDM demultiplexer: serial input side and the
// registered per-channel outputs with framing status.
interface tdm_demux_if;
  logic       din;
  logic       din_valid;
  logic       sync;
  logic       y1;
  logic       y2;
  logic       y3;
  logic       y4;
  logic [1:0] s;
  logic       frame_valid;
  logic       locked;
  logic       sync_err;

  modport master (
    output din, din_valid, sync,
    input  y1, y2, y3, y4, s, frame_valid, locked, sync_err
  );

  modport slave (
    input  din, din_valid, sync,
    output y1, y2, y3, y4, s, frame_valid, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux.sv
// 4-slot serial TDM demultiplexer with HUNT/ACQ/LOCKED frame alignment,
// flywheel tolerance of framing errors and whole-frame registered delivery.
module tdm_demux #(
  parameter int LOCK_FRAMES = 2,
  parameter int LOSS_ERRS   = 2
) (
  input  logic        clk,
  input  logic        rst,
  tdm_demux_if.slave  bus
);

  localparam int GW = ($clog2(LOCK_FRAMES + 1) < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam int EW = ($clog2(LOSS_ERRS + 1) < 1) ? 1 : $clog2(LOSS_ERRS + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      slot_q, slot_d;
  logic [2:0]      sh_q, sh_d;
  logic [GW-1:0]   gcnt_q, gcnt_d;
  logic [EW-1:0]   ecnt_q, ecnt_d;
  logic [3:0]      y_q, y_d;
  logic            fv_q, fv_d;
  logic            err_q, err_d;
  logic            bad_q, bad_d;
  logic            lost;
  logic            lock_now;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      slot_q  <= 2'd0;
      sh_q    <= 3'd0;
      gcnt_q  <= '0;
      ecnt_q  <= '0;
      y_q     <= 4'd0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      sh_q    <= sh_d;
      gcnt_q  <= gcnt_d;
      ecnt_q  <= ecnt_d;
      y_q     <= y_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
      bad_q   <= bad_d;
    end
  end

  // bad_q marks a frame whose slot 0 was flywheeled in, so it is never delivered
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    sh_d     = sh_q;
    gcnt_d   = gcnt_q;
    ecnt_d   = ecnt_q;
    y_d      = y_q;
    bad_d    = bad_q;
    fv_d     = 1'b0;
    err_d    = 1'b0;
    lost     = (int'(ecnt_q) + 1) >= LOSS_ERRS;
    lock_now = (int'(gcnt_q) + 1) >= LOCK_FRAMES;

    if (bus.din_valid) begin
      case (state_q)
        HUNT: begin
          if (bus.sync) begin
            sh_d[0] = bus.din;
            slot_d  = 2'd1;
            gcnt_d  = '0;
            bad_d   = 1'b0;
            state_d = ACQ;
          end
        end

        default: begin
          if (bus.sync) begin
            sh_d[0] = bus.din;
            slot_d  = 2'd1;
            bad_d   = 1'b0;
            if (slot_q != 2'd0) begin
              err_d = 1'b1;
              if (state_q == ACQ) begin
                gcnt_d = '0;
              end else begin
                ecnt_d = ecnt_q + EW'(1);
                if (lost) begin
                  state_d = HUNT;
                  slot_d  = 2'd0;
                end
              end
            end
          end else if (slot_q == 2'd0) begin
            err_d = 1'b1;
            if (state_q == ACQ) begin
              state_d = HUNT;
              slot_d  = 2'd0;
            end else begin
              ecnt_d  = ecnt_q + EW'(1);
              sh_d[0] = bus.din;
              slot_d  = 2'd1;
              bad_d   = 1'b1;
              if (lost) begin
                state_d = HUNT;
                slot_d  = 2'd0;
              end
            end
          end else if (slot_q != 2'd3) begin
            sh_d[slot_q] = bus.din;
            slot_d       = slot_q + 2'd1;
          end else begin
            slot_d = 2'd0;
            if (state_q == ACQ) begin
              gcnt_d = gcnt_q + GW'(1);
              if (lock_now) begin
                state_d = LOCKED;
                y_d     = {bus.din, sh_q};
                fv_d    = 1'b1;
                ecnt_d  = '0;
              end
            end else if (!bad_q) begin
              y_d    = {bus.din, sh_q};
              fv_d   = 1'b1;
              ecnt_d = '0;
            end
          end
        end
      endcase
    end
  end

  assign bus.y1          = y_q[0];
  assign bus.y2          = y_q[1];
  assign bus.y3          = y_q[2];
  assign bus.y4          = y_q[3];
  assign bus.s           = slot_q;
  assign bus.frame_valid = fv_q;
  assign bus.sync_err    = err_q;
  assign bus.locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux: expected frames are queued as they are
// sent and popped whenever the DUT pulses frame_valid.
module tb_tdm_demux;
  logic clk = 1'b0;
  logic rst = 1'b1;

  tdm_demux_if bus();

  tdm_demux #(.LOCK_FRAMES(2), .LOSS_ERRS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         error_count = 0;
  int         check_count = 0;
  logic [3:0] sb_q[$];
  logic [3:0] stream[4] = '{4'b1000, 4'b1100, 4'b1000, 4'b1001};
  logic [3:0] gap_frame = 4'b1001;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [3:0] y_word();
    return {bus.y1, bus.y2, bus.y3, bus.y4};
  endfunction

  task automatic applyStimulus(input logic d, input logic sy, input logic v);
    @(negedge clk);
    bus.din       = d;
    bus.sync      = sy;
    bus.din_valid = v;
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
  endtask

  // frame bits are written slot 0 first, i.e. bits[3] is y1
  task automatic sendFrame(input logic [3:0] bits, input bit deliver);
    if (deliver) sb_q.push_back(bits);
    for (int i = 0; i < 4; i++) applyStimulus(bits[3-i], i == 0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.frame_valid) begin
      if (sb_q.size() == 0) checkOutput("unexpected_frame", 32'(bus.frame_valid), 0);
      else checkOutput("frame", 32'(y_word()), 32'(sb_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", error_count);
    $fatal(1);
  end

  initial begin
    bus.din       = 1'b0;
    bus.sync      = 1'b0;
    bus.din_valid = 1'b0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_y", 32'(y_word()), 0);
    checkOutput("rst_s", 32'(bus.s), 0);
    checkOutput("rst_locked", 32'(bus.locked), 0);
    checkOutput("rst_fv", 32'(bus.frame_valid), 0);
    checkOutput("rst_err", 32'(bus.sync_err), 0);
    @(negedge clk) rst = 1'b0;

    sendFrame(4'b1000, 0);
    checkOutput("acq_locked", 32'(bus.locked), 0);
    checkOutput("acq_fv", 32'(bus.frame_valid), 0);
    sendFrame(4'b1100, 1);
    checkOutput("lock_locked", 32'(bus.locked), 1);
    checkOutput("lock_fv", 32'(bus.frame_valid), 1);
    checkOutput("lock_y", 32'(y_word()), 32'(4'b1100));
    applyStimulus(0, 0, 0);
    checkOutput("lock_fv_pulse", 32'(bus.frame_valid), 0);

    for (int f = 0; f < 4; f++) begin
      sb_q.push_back(stream[f]);
      for (int i = 0; i < 4; i++) begin
        checkOutput("stream_s_pre", 32'(bus.s), i);
        applyStimulus(stream[f][3-i], i == 0, 1'b1);
        checkOutput("stream_s_post", 32'(bus.s), (i + 1) % 4);
      end
      checkOutput("stream_fv", 32'(bus.frame_valid), 1);
      checkOutput("stream_y", 32'(y_word()), 32'(stream[f]));
    end

    sb_q.push_back(gap_frame);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(gap_frame[3-i], i == 0, 1'b1);
      checkOutput("gap_s", 32'(bus.s), (i + 1) % 4);
      checkOutput("gap_fv", 32'(bus.frame_valid), (i == 3) ? 1 : 0);
      for (int g = 0; g < 3; g++) begin
        applyStimulus(0, 0, 0);
        checkOutput("gap_s_hold", 32'(bus.s), (i + 1) % 4);
        checkOutput("gap_fv_idle", 32'(bus.frame_valid), 0);
      end
    end
    checkOutput("gap_y", 32'(y_word()), 32'(4'b1001));

    applyStimulus(1, 1, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 1, 1);
    checkOutput("early_err", 32'(bus.sync_err), 1);
    checkOutput("early_s", 32'(bus.s), 1);
    checkOutput("early_fv", 32'(bus.frame_valid), 0);
    checkOutput("early_locked", 32'(bus.locked), 1);
    applyStimulus(0, 0, 1);
    checkOutput("early_err_pulse", 32'(bus.sync_err), 0);
    applyStimulus(1, 1, 1);
    checkOutput("loss_err", 32'(bus.sync_err), 1);
    checkOutput("loss_locked", 32'(bus.locked), 0);
    checkOutput("loss_s", 32'(bus.s), 0);
    checkOutput("loss_y_held", 32'(y_word()), 32'(4'b1001));

    sendFrame(4'b1010, 0);
    checkOutput("acq2_locked", 32'(bus.locked), 0);
    applyStimulus(0, 0, 1);
    checkOutput("miss_err", 32'(bus.sync_err), 1);
    checkOutput("miss_locked", 32'(bus.locked), 0);
    checkOutput("miss_s", 32'(bus.s), 0);
    applyStimulus(1, 0, 1);
    checkOutput("hunt_ignore_s", 32'(bus.s), 0);
    checkOutput("hunt_ignore_err", 32'(bus.sync_err), 0);
    sendFrame(4'b0110, 0);
    checkOutput("relock1_locked", 32'(bus.locked), 0);
    sendFrame(4'b1001, 1);
    checkOutput("relock2_locked", 32'(bus.locked), 1);

    applyStimulus(0, 1, 1);
    applyStimulus(1, 0, 1);
    checkOutput("midframe_s", 32'(bus.s), 2);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_y", 32'(y_word()), 0);
    checkOutput("arst_s", 32'(bus.s), 0);
    checkOutput("arst_locked", 32'(bus.locked), 0);
    checkOutput("arst_fv", 32'(bus.frame_valid), 0);
    checkOutput("arst_err", 32'(bus.sync_err), 0);
    @(negedge clk) rst = 1'b0;
    sendFrame(4'b1111, 0);
    checkOutput("post_rst1_locked", 32'(bus.locked), 0);
    checkOutput("post_rst1_fv", 32'(bus.frame_valid), 0);
    sendFrame(4'b0101, 1);
    checkOutput("post_rst2_locked", 32'(bus.locked), 1);
    checkOutput("post_rst2_y", 32'(y_word()), 32'(4'b0101));

    applyStimulus(1, 0, 1);
    checkOutput("fly_err", 32'(bus.sync_err), 1);
    checkOutput("fly_s", 32'(bus.s), 1);
    checkOutput("fly_locked", 32'(bus.locked), 1);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 1);
    checkOutput("fly_no_fv", 32'(bus.frame_valid), 0);
    checkOutput("fly_y_held", 32'(y_word()), 32'(4'b0101));
    checkOutput("fly_s_wrap", 32'(bus.s), 0);
    sendFrame(4'b0011, 1);
    checkOutput("fly_recover_fv", 32'(bus.frame_valid), 1);

    applyStimulus(1, 1, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 1, 1);
    checkOutput("slot3_err", 32'(bus.sync_err), 1);
    checkOutput("slot3_fv", 32'(bus.frame_valid), 0);
    checkOutput("slot3_s", 32'(bus.s), 1);
    checkOutput("slot3_locked", 32'(bus.locked), 1);
    checkOutput("slot3_y", 32'(y_word()), 32'(4'b0011));

    applyStimulus(0, 0, 0);
    checkOutput("sb_empty", 32'(sb_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end
endmodule
